sys_cmd_ctrl_mc: RTL and testbench

Parametrised next-generation UART command decoder for the system controller. It parses command frames from the UART RX byte stream and drives the register file and the ALU. It adds a burst register-write command, an inter-byte/response timeout and error reporting. A single ready/valid response channel feeds the TX controller, so responses are held until accepted rather than pulsed.

---
 rtl/sys_ctrl_pkg.sv | 29 ++
 rtl/sys_cmd_timeout.sv | 31 +++
 rtl/sys_cmd_ctrl_mc.sv | 229 ++++++++++++++++++++++
 tb/tb_sys_cmd_ctrl_mc.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_ctrl_pkg.sv
// Shared definitions for the system controller command path: opcodes and FSM states.
// Also used by the TX controller.
package sys_ctrl_pkg;

    localparam int unsigned OP_WIDTH = 8;

    localparam logic [OP_WIDTH-1:0] OP_WRITE = 8'hAA;
    localparam logic [OP_WIDTH-1:0] OP_READ  = 8'hBB;
    localparam logic [OP_WIDTH-1:0] OP_ALU   = 8'hCC;
    localparam logic [OP_WIDTH-1:0] OP_NOP   = 8'hDD;
    localparam logic [OP_WIDTH-1:0] OP_BURST = 8'hEE;

    typedef enum logic [3:0] {
        S_IDLE     = 4'd0,
        S_WR_ADDR  = 4'd1,
        S_WR_DATA  = 4'd2,
        S_RD_ADDR  = 4'd3,
        S_RD_WAIT  = 4'd4,
        S_OPA      = 4'd5,
        S_OPB      = 4'd6,
        S_FUN      = 4'd7,
        S_ALU_WAIT = 4'd8,
        S_BW_ADDR  = 4'd9,
        S_BW_CNT   = 4'd10,
        S_BW_DATA  = 4'd11,
        S_RESP     = 4'd12
    } state_e;

endpackage

// File: rtl/sys_cmd_timeout.sv
// Inactivity watchdog: reloads on clear or while idle, counts down while running,
// and flags expiry once TIMEOUT_CYCLES cycles have passed since the last reload.
module sys_cmd_timeout #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic run,
    output logic expire_c
);

    localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] LOAD = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    logic [CNT_WIDTH-1:0] count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= LOAD;
        end else if (clear || !run) begin
            count <= LOAD;
        end else if (count != '0) begin
            count <= count - CNT_WIDTH'(1);
        end
    end

    // Zero is reached in the TIMEOUT_CYCLES-th cycle after reload.
    assign expire_c = run && (count == '0);

endmodule

// File: rtl/sys_cmd_ctrl_mc.sv
// UART command decoder for the system controller: parses rx frames, drives the
// register file and ALU, and returns read/ALU results over a ready/valid channel.
module sys_cmd_ctrl_mc
    import sys_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned ADDR_WIDTH     = 4,
    parameter int unsigned FUN_WIDTH      = 4,
    parameter int unsigned OPA_ADDR       = 0,
    parameter int unsigned OPB_ADDR       = 1,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DATA_WIDTH-1:0]   rx_data,
    input  logic                    rx_valid,
    input  logic [DATA_WIDTH-1:0]   rd_data,
    input  logic                    rd_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_out,
    input  logic                    alu_valid,
    output logic                    reg_wr_en,
    output logic                    reg_rd_en,
    output logic [ADDR_WIDTH-1:0]   reg_addr,
    output logic [DATA_WIDTH-1:0]   reg_wr_data,
    output logic                    alu_en,
    output logic [FUN_WIDTH-1:0]    alu_fun,
    output logic                    clk_gate_en,
    output logic [2*DATA_WIDTH-1:0] resp_data,
    output logic                    resp_two,
    output logic                    resp_valid,
    input  logic                    resp_ready,
    output logic                    busy,
    output logic                    cmd_err,
    output logic                    timeout_err,
    output logic                    overrun_err
);

    state_e state, state_d;

    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [DATA_WIDTH-1:0]   cnt_q, cnt_d;
    logic                    reg_wr_en_d, reg_rd_en_d, alu_en_d, clk_gate_en_d;
    logic [ADDR_WIDTH-1:0]   reg_addr_d;
    logic [DATA_WIDTH-1:0]   reg_wr_data_d;
    logic [FUN_WIDTH-1:0]    alu_fun_d;
    logic [2*DATA_WIDTH-1:0] resp_data_d;
    logic                    resp_two_d, resp_valid_d, busy_d;
    logic                    cmd_err_d, timeout_err_d, overrun_err_d;

    logic collecting_c, waiting_c, to_run_c, to_clear_c, to_expire_c;

    assign collecting_c = state inside {S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_OPA, S_OPB,
                                        S_FUN, S_BW_ADDR, S_BW_CNT, S_BW_DATA};
    assign waiting_c    = state inside {S_RD_WAIT, S_ALU_WAIT};
    assign to_run_c     = collecting_c || waiting_c;
    assign to_clear_c   = (rx_valid && collecting_c) || (state_d != state);

    sys_cmd_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk      (clk),
        .rst      (rst),
        .clear    (to_clear_c),
        .run      (to_run_c),
        .expire_c (to_expire_c)
    );

    // State and all registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= S_IDLE;
            addr_q      <= '0;
            cnt_q       <= '0;
            reg_wr_en   <= 1'b0;
            reg_rd_en   <= 1'b0;
            reg_addr    <= '0;
            reg_wr_data <= '0;
            alu_en      <= 1'b0;
            alu_fun     <= '0;
            clk_gate_en <= 1'b0;
            resp_data   <= '0;
            resp_two    <= 1'b0;
            resp_valid  <= 1'b0;
            busy        <= 1'b0;
            cmd_err     <= 1'b0;
            timeout_err <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            state       <= state_d;
            addr_q      <= addr_d;
            cnt_q       <= cnt_d;
            reg_wr_en   <= reg_wr_en_d;
            reg_rd_en   <= reg_rd_en_d;
            reg_addr    <= reg_addr_d;
            reg_wr_data <= reg_wr_data_d;
            alu_en      <= alu_en_d;
            alu_fun     <= alu_fun_d;
            clk_gate_en <= clk_gate_en_d;
            resp_data   <= resp_data_d;
            resp_two    <= resp_two_d;
            resp_valid  <= resp_valid_d;
            busy        <= busy_d;
            cmd_err     <= cmd_err_d;
            timeout_err <= timeout_err_d;
            overrun_err <= overrun_err_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d       = state;
        addr_d        = addr_q;
        cnt_d         = cnt_q;
        reg_wr_en_d   = 1'b0;
        reg_addr_d    = reg_addr;
        reg_wr_data_d = reg_wr_data;
        alu_en_d      = 1'b0;
        alu_fun_d     = alu_fun;
        resp_data_d   = resp_data;
        resp_two_d    = resp_two;
        cmd_err_d     = 1'b0;
        timeout_err_d = 1'b0;
        overrun_err_d = 1'b0;

        case (state)
            S_IDLE: begin
                if (rx_valid) begin
                    case (rx_data)
                        DATA_WIDTH'(OP_WRITE): state_d = S_WR_ADDR;
                        DATA_WIDTH'(OP_READ):  state_d = S_RD_ADDR;
                        DATA_WIDTH'(OP_ALU):   state_d = S_OPA;
                        DATA_WIDTH'(OP_NOP):   state_d = S_FUN;
                        DATA_WIDTH'(OP_BURST): state_d = S_BW_ADDR;
                        default:               cmd_err_d = 1'b1;
                    endcase
                end
            end
            S_WR_ADDR, S_BW_ADDR: begin
                if (rx_valid) begin
                    addr_d  = rx_data[ADDR_WIDTH-1:0];
                    state_d = (state == S_WR_ADDR) ? S_WR_DATA : S_BW_CNT;
                end
            end
            S_WR_DATA, S_OPA, S_OPB: begin
                if (rx_valid) begin
                    reg_wr_en_d   = 1'b1;
                    reg_wr_data_d = rx_data;
                    if (state == S_WR_DATA) begin
                        reg_addr_d = addr_q;
                        state_d    = S_IDLE;
                    end else if (state == S_OPA) begin
                        reg_addr_d = ADDR_WIDTH'(OPA_ADDR);
                        state_d    = S_OPB;
                    end else begin
                        reg_addr_d = ADDR_WIDTH'(OPB_ADDR);
                        state_d    = S_FUN;
                    end
                end
            end
            S_RD_ADDR: begin
                if (rx_valid) begin
                    reg_addr_d = rx_data[ADDR_WIDTH-1:0];
                    state_d    = S_RD_WAIT;
                end
            end
            S_RD_WAIT: begin
                if (rd_valid) begin
                    resp_data_d = {{DATA_WIDTH{1'b0}}, rd_data};
                    resp_two_d  = 1'b0;
                    state_d     = S_RESP;
                end
            end
            S_FUN: begin
                if (rx_valid) begin
                    alu_en_d  = 1'b1;
                    alu_fun_d = rx_data[FUN_WIDTH-1:0];
                    state_d   = S_ALU_WAIT;
                end
            end
            S_ALU_WAIT: begin
                if (alu_valid) begin
                    resp_data_d = alu_out;
                    resp_two_d  = 1'b1;
                    state_d     = S_RESP;
                end
            end
            S_BW_CNT: begin
                if (rx_valid) begin
                    cnt_d   = rx_data;
                    state_d = (rx_data == '0) ? S_IDLE : S_BW_DATA;
                end
            end
            S_BW_DATA: begin
                if (rx_valid) begin
                    reg_wr_en_d   = 1'b1;
                    reg_addr_d    = addr_q;
                    reg_wr_data_d = rx_data;
                    addr_d        = addr_q + ADDR_WIDTH'(1);
                    cnt_d         = cnt_q - DATA_WIDTH'(1);
                    if (cnt_q == DATA_WIDTH'(1)) begin
                        state_d = S_IDLE;
                    end
                end
            end
            S_RESP: begin
                if (resp_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // An accepted final byte has already moved state_d on; expiry only aborts a stalled frame.
        if (to_expire_c && (state_d == state) && !(rx_valid && collecting_c)) begin
            state_d       = S_IDLE;
            timeout_err_d = 1'b1;
        end

        if (rx_valid && (waiting_c || state == S_RESP)) begin
            overrun_err_d = 1'b1;
        end
    end

    assign reg_rd_en_d   = (state_d == S_RD_WAIT);
    assign clk_gate_en_d = (state_d == S_FUN) || (state_d == S_ALU_WAIT);
    assign resp_valid_d  = (state_d == S_RESP);
    assign busy_d        = (state_d != S_IDLE);

endmodule

// File: tb/tb_sys_cmd_ctrl_mc.sv
// Directed self-checking bench for sys_cmd_ctrl_mc (8-bit data, 4-bit address,
// timeout of 16 cycles).
module tb_sys_cmd_ctrl_mc;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [15:0] alu_out;
    logic        alu_valid;
    logic        reg_wr_en, reg_rd_en;
    logic [3:0]  reg_addr;
    logic [7:0]  reg_wr_data;
    logic        alu_en;
    logic [3:0]  alu_fun;
    logic        clk_gate_en;
    logic [15:0] resp_data;
    logic        resp_two, resp_valid, resp_ready;
    logic        busy, cmd_err, timeout_err, overrun_err;

    int total = 0;
    int bad   = 0;

    sys_cmd_ctrl_mc #(
        .DATA_WIDTH     (8),
        .ADDR_WIDTH     (4),
        .FUN_WIDTH      (4),
        .OPA_ADDR       (0),
        .OPB_ADDR       (1),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .alu_out     (alu_out),
        .alu_valid   (alu_valid),
        .reg_wr_en   (reg_wr_en),
        .reg_rd_en   (reg_rd_en),
        .reg_addr    (reg_addr),
        .reg_wr_data (reg_wr_data),
        .alu_en      (alu_en),
        .alu_fun     (alu_fun),
        .clk_gate_en (clk_gate_en),
        .resp_data   (resp_data),
        .resp_two    (resp_two),
        .resp_valid  (resp_valid),
        .resp_ready  (resp_ready),
        .busy        (busy),
        .cmd_err     (cmd_err),
        .timeout_err (timeout_err),
        .overrun_err (overrun_err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Called at a negedge; presents one byte for exactly one rising edge.
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    function automatic logic [41:0] all_outs();
        return {reg_wr_en, reg_rd_en, reg_addr, reg_wr_data, alu_en, alu_fun, clk_gate_en,
                resp_data, resp_two, resp_valid, busy, cmd_err, timeout_err, overrun_err};
    endfunction

    task automatic test_reset();
        rst = 1'b0; rx_data = '0; rx_valid = 1'b0; rd_data = '0; rd_valid = 1'b0;
        alu_out = '0; alu_valid = 1'b0; resp_ready = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if (all_outs() !== 42'd0) begin
            bad++; $display("FAIL reset_outputs: got %h want 0", all_outs());
        end
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_write();
        send_byte(8'hAA);
        total++;
        if ({busy, reg_wr_en} !== 2'b10) begin
            bad++; $display("FAIL wr_after_opcode: got %b want 10", {busy, reg_wr_en});
        end
        send_byte(8'h05);
        send_byte(8'h3C);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data, busy} !== {1'b1, 4'h5, 8'h3C, 1'b0}) begin
            bad++; $display("FAIL wr_strobe: got %h want %h",
                            {reg_wr_en, reg_addr, reg_wr_data, busy}, {1'b1, 4'h5, 8'h3C, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({reg_wr_en, busy} !== 2'b00) begin
            bad++; $display("FAIL wr_one_cycle: got %b want 00", {reg_wr_en, busy});
        end
    endtask

    task automatic test_read_backpressure();
        int held = 0;
        send_byte(8'hBB);
        send_byte(8'h07);
        total++;
        if ({reg_rd_en, reg_addr, busy} !== {1'b1, 4'h7, 1'b1}) begin
            bad++; $display("FAIL rd_request: got %h want %h", {reg_rd_en, reg_addr, busy}, {1'b1, 4'h7, 1'b1});
        end
        rd_data = 8'h5A; rd_valid = 1'b1;
        @(negedge clk);
        rd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if ({resp_valid, resp_data, resp_two, reg_rd_en} === {1'b1, 16'h005A, 1'b0, 1'b0}) held++;
            @(negedge clk);
        end
        total++;
        if (held !== 10) begin
            bad++; $display("FAIL rd_resp_held: got %0d stable cycles want 10", held);
        end
        total++;
        if ({resp_valid, resp_data, resp_two} !== {1'b1, 16'h005A, 1'b0}) begin
            bad++; $display("FAIL rd_resp_before_ready: got %h want %h", {resp_valid, resp_data, resp_two}, {1'b1, 16'h005A, 1'b0});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        total++;
        if ({resp_valid, busy} !== 2'b00) begin
            bad++; $display("FAIL rd_resp_drop: got %b want 00", {resp_valid, busy});
        end
    endtask

    task automatic test_alu();
        send_byte(8'hCC);
        send_byte(8'h10);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'h0, 8'h10}) begin
            bad++; $display("FAIL alu_opa_write: got %h want %h", {reg_wr_en, reg_addr, reg_wr_data}, {1'b1, 4'h0, 8'h10});
        end
        send_byte(8'h20);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data, clk_gate_en} !== {1'b1, 4'h1, 8'h20, 1'b1}) begin
            bad++; $display("FAIL alu_opb_write: got %h want %h", {reg_wr_en, reg_addr, reg_wr_data, clk_gate_en}, {1'b1, 4'h1, 8'h20, 1'b1});
        end
        send_byte(8'h02);
        total++;
        if ({alu_en, alu_fun, clk_gate_en, reg_wr_en} !== {1'b1, 4'h2, 1'b1, 1'b0}) begin
            bad++; $display("FAIL alu_start: got %h want %h", {alu_en, alu_fun, clk_gate_en, reg_wr_en}, {1'b1, 4'h2, 1'b1, 1'b0});
        end
        @(negedge clk);
        total++;
        if ({alu_en, clk_gate_en} !== 2'b01) begin
            bad++; $display("FAIL alu_wait_gate: got %b want 01", {alu_en, clk_gate_en});
        end
        alu_out = 16'h0030; alu_valid = 1'b1;
        @(negedge clk);
        alu_valid = 1'b0;
        total++;
        if ({resp_valid, resp_data, resp_two, clk_gate_en} !== {1'b1, 16'h0030, 1'b1, 1'b0}) begin
            bad++; $display("FAIL alu_resp: got %h want %h", {resp_valid, resp_data, resp_two, clk_gate_en}, {1'b1, 16'h0030, 1'b1, 1'b0});
        end
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
    endtask

    task automatic test_burst();
        send_byte(8'hEE);
        send_byte(8'h0E);
        send_byte(8'h03);
        send_byte(8'h11);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'hE, 8'h11}) begin
            bad++; $display("FAIL burst_w0: got %h want %h", {reg_wr_en, reg_addr, reg_wr_data}, {1'b1, 4'hE, 8'h11});
        end
        send_byte(8'h22);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data} !== {1'b1, 4'hF, 8'h22}) begin
            bad++; $display("FAIL burst_w1: got %h want %h", {reg_wr_en, reg_addr, reg_wr_data}, {1'b1, 4'hF, 8'h22});
        end
        send_byte(8'h33);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data, busy} !== {1'b1, 4'h0, 8'h33, 1'b0}) begin
            bad++; $display("FAIL burst_wrap: got %h want %h", {reg_wr_en, reg_addr, reg_wr_data, busy}, {1'b1, 4'h0, 8'h33, 1'b0});
        end
        send_byte(8'hEE);
        send_byte(8'h02);
        send_byte(8'h00);
        total++;
        if ({reg_wr_en, busy} !== 2'b00) begin
            bad++; $display("FAIL burst_zero: got %b want 00", {reg_wr_en, busy});
        end
    endtask

    task automatic test_timeout_cmd_err();
        int wr_seen = 0;
        int err_at  = -1;
        send_byte(8'hAA);
        send_byte(8'h03);
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (reg_wr_en) wr_seen++;
            if (timeout_err && err_at < 0) err_at = i;
        end
        total++;
        if (err_at !== 16 || wr_seen !== 0) begin
            bad++; $display("FAIL timeout_pulse: got cycle %0d writes %0d want cycle 16 writes 0", err_at, wr_seen);
        end
        total++;
        if ({timeout_err, busy} !== 2'b00) begin
            bad++; $display("FAIL timeout_end: got %b want 00", {timeout_err, busy});
        end
        // Final byte arriving in the expiry cycle completes the frame.
        send_byte(8'hAA);
        send_byte(8'h03);
        repeat (15) @(negedge clk);
        send_byte(8'h77);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data, timeout_err, busy} !== {1'b1, 4'h3, 8'h77, 1'b0, 1'b0}) begin
            bad++; $display("FAIL timeout_byte_wins: got %h want %h",
                            {reg_wr_en, reg_addr, reg_wr_data, timeout_err, busy}, {1'b1, 4'h3, 8'h77, 1'b0, 1'b0});
        end
        send_byte(8'h55);
        total++;
        if ({cmd_err, busy} !== 2'b10) begin
            bad++; $display("FAIL cmd_err_pulse: got %b want 10", {cmd_err, busy});
        end
        @(negedge clk);
        total++;
        if (cmd_err !== 1'b0) begin
            bad++; $display("FAIL cmd_err_one_cycle: got %b want 0", cmd_err);
        end
    endtask

    task automatic test_overrun_reset();
        send_byte(8'hDD);
        send_byte(8'h07);
        send_byte(8'h99);
        total++;
        if ({overrun_err, clk_gate_en, busy, resp_valid} !== 4'b1110) begin
            bad++; $display("FAIL overrun_alu_wait: got %b want 1110", {overrun_err, clk_gate_en, busy, resp_valid});
        end
        alu_out = 16'hBEEF; alu_valid = 1'b1;
        @(negedge clk);
        alu_valid = 1'b0;
        total++;
        if ({overrun_err, resp_valid, resp_data} !== {1'b0, 1'b1, 16'hBEEF}) begin
            bad++; $display("FAIL overrun_state_kept: got %h want %h", {overrun_err, resp_valid, resp_data}, {1'b0, 1'b1, 16'hBEEF});
        end
        rx_data = 8'h12; rx_valid = 1'b1; resp_ready = 1'b1;
        @(negedge clk);
        rx_valid = 1'b0; resp_ready = 1'b0;
        total++;
        if ({resp_valid, overrun_err, busy} !== 3'b010) begin
            bad++; $display("FAIL overrun_with_ready: got %b want 010", {resp_valid, overrun_err, busy});
        end
        send_byte(8'hEE);
        send_byte(8'h02);
        send_byte(8'h02);
        send_byte(8'h44);
        rst = 1'b0;
        #1;
        total++;
        if (all_outs() !== 42'd0) begin
            bad++; $display("FAIL reset_mid_burst: got %h want 0", all_outs());
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_byte(8'hAA);
        send_byte(8'h09);
        send_byte(8'h5C);
        total++;
        if ({reg_wr_en, reg_addr, reg_wr_data, busy} !== {1'b1, 4'h9, 8'h5C, 1'b0}) begin
            bad++; $display("FAIL write_after_reset: got %h want %h",
                            {reg_wr_en, reg_addr, reg_wr_data, busy}, {1'b1, 4'h9, 8'h5C, 1'b0});
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read_backpressure();
        test_alu();
        test_burst();
        test_timeout_cmd_err();
        test_overrun_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
